// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the bit-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell processes one bit pair
// per clock, LSB first, with the ripple carry held in a flip-flop.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_shift;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;

    assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    // New sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
    assign s_shift = WIDTH'({fa_s, s_sr} >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only change on the final RUN edge, so they stay put
    // through backpressure and after returning to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_shift;
                    carry <= fa_c;
                    if (cnt == LAST) begin
                        sum_q  <= s_shift;
                        cout_q <= fa_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule
